// File: rtl/alu_issue_stage_if.sv
// ID->EX handshake and payload bundle for the ALU issue stage.
// master = ID-side driver (instruction source plus EX consumer), slave = the issue stage itself.
interface alu_issue_stage_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_control;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [4:0]  ex_dest;
  logic        ex_regwrite;
  logic        ex_is_branch;
  logic        ex_illegal;

  modport master (
    output id_valid, id_instr, id_rs_data, id_rt_data, flush, ex_ready,
    input  id_ready, ex_valid, ex_alu_control, ex_a, ex_b, ex_dest,
           ex_regwrite, ex_is_branch, ex_illegal
  );

  modport slave (
    input  id_valid, id_instr, id_rs_data, id_rt_data, flush, ex_ready,
    output id_ready, ex_valid, ex_alu_control, ex_a, ex_b, ex_dest,
           ex_regwrite, ex_is_branch, ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes a MIPS instruction into ALU control and operands and holds
// the result in a single valid/ready slot with stall, flush and a handoff counter.
module alu_issue_stage #(
  parameter int CNT_W       = 32,
  parameter bit SUPPRESS_R0 = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_issue_stage_if.slave     bus,
  output logic [CNT_W-1:0]     issue_count
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] sext_imm;
  logic [31:0] zext_imm;

  assign op       = bus.id_instr[31:26];
  assign rt       = bus.id_instr[20:16];
  assign rd       = bus.id_instr[15:11];
  assign shamt    = bus.id_instr[10:6];
  assign funct    = bus.id_instr[5:0];
  assign imm      = bus.id_instr[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};

  logic [3:0]  ctl_next;
  logic [31:0] a_next;
  logic [31:0] b_next;
  logic [4:0]  dest_next;
  logic        regwrite_next;
  logic        branch_next;
  logic        illegal_next;

  always_comb begin
    ctl_next      = 4'b0000;
    a_next        = bus.id_rs_data;
    b_next        = bus.id_rt_data;
    dest_next     = rt;
    regwrite_next = 1'b1;
    branch_next   = 1'b0;
    illegal_next  = 1'b0;
    case (op)
      6'h00: begin
        dest_next = rd;
        case (funct)
          6'h20, 6'h21: ctl_next = 4'b0010;
          6'h22, 6'h23: ctl_next = 4'b0110;
          6'h24:        ctl_next = 4'b0000;
          6'h25:        ctl_next = 4'b0001;
          6'h26:        ctl_next = 4'b0011;
          6'h27:        ctl_next = 4'b1100;
          6'h2A:        ctl_next = 4'b0111;
          6'h00: begin ctl_next = 4'b0100; a_next = {27'b0, shamt}; end
          6'h02: begin ctl_next = 4'b0101; a_next = {27'b0, shamt}; end
          6'h03: begin ctl_next = 4'b1000; a_next = {27'b0, shamt}; end
          6'h04: begin ctl_next = 4'b0100; a_next = {27'b0, bus.id_rs_data[4:0]}; end
          6'h06: begin ctl_next = 4'b0101; a_next = {27'b0, bus.id_rs_data[4:0]}; end
          6'h07: begin ctl_next = 4'b1000; a_next = {27'b0, bus.id_rs_data[4:0]}; end
          default:      illegal_next = 1'b1;
        endcase
      end
      6'h08, 6'h09, 6'h23: begin ctl_next = 4'b0010; b_next = sext_imm; end
      6'h0A: begin ctl_next = 4'b0111; b_next = sext_imm; end
      6'h0C: begin ctl_next = 4'b0000; b_next = zext_imm; end
      6'h0D: begin ctl_next = 4'b0001; b_next = zext_imm; end
      6'h0E: begin ctl_next = 4'b0011; b_next = zext_imm; end
      6'h2B: begin ctl_next = 4'b0010; b_next = sext_imm; regwrite_next = 1'b0; end
      // lui is executed as a left shift of the zero-extended immediate by 16
      6'h0F: begin ctl_next = 4'b0100; a_next = 32'd16; b_next = zext_imm; end
      6'h04: begin ctl_next = 4'b1001; regwrite_next = 1'b0; branch_next = 1'b1; end
      6'h05: begin ctl_next = 4'b1010; regwrite_next = 1'b0; branch_next = 1'b1; end
      default: illegal_next = 1'b1;
    endcase
    if (illegal_next) begin
      ctl_next      = 4'b0000;
      a_next        = 32'd0;
      b_next        = 32'd0;
      dest_next     = 5'd0;
      regwrite_next = 1'b0;
      branch_next   = 1'b0;
    end
    if (SUPPRESS_R0 && (dest_next == 5'd0)) regwrite_next = 1'b0;
  end

  logic             ex_valid_reg;
  logic [3:0]       ctl_reg;
  logic [31:0]      a_reg;
  logic [31:0]      b_reg;
  logic [4:0]       dest_reg;
  logic             regwrite_reg;
  logic             branch_reg;
  logic             illegal_reg;
  logic [CNT_W-1:0] count_reg;
  logic             id_ready_int;
  logic             accept;

  assign id_ready_int = !ex_valid_reg || bus.ex_ready;
  assign accept       = bus.id_valid && id_ready_int && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_reg <= 1'b0;
      ctl_reg      <= 4'b0000;
      a_reg        <= 32'd0;
      b_reg        <= 32'd0;
      dest_reg     <= 5'd0;
      regwrite_reg <= 1'b0;
      branch_reg   <= 1'b0;
      illegal_reg  <= 1'b0;
      count_reg    <= '0;
    end else begin
      if (accept) begin
        ex_valid_reg <= 1'b1;
        ctl_reg      <= ctl_next;
        a_reg        <= a_next;
        b_reg        <= b_next;
        dest_reg     <= dest_next;
        regwrite_reg <= regwrite_next;
        branch_reg   <= branch_next;
        illegal_reg  <= illegal_next;
      end else if (bus.ex_ready || bus.flush) begin
        // payload is left stale; only the valid bit drops
        ex_valid_reg <= 1'b0;
      end
      if (ex_valid_reg && bus.ex_ready) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.id_ready       = id_ready_int;
  assign bus.ex_valid       = ex_valid_reg;
  assign bus.ex_alu_control = ctl_reg;
  assign bus.ex_a           = a_reg;
  assign bus.ex_b           = b_reg;
  assign bus.ex_dest        = dest_reg;
  assign bus.ex_regwrite    = regwrite_reg;
  assign bus.ex_is_branch   = branch_reg;
  assign bus.ex_illegal     = illegal_reg;
  assign issue_count        = count_reg;

endmodule
